// File: rtl/uart_rx_nibble.sv
// uart_rx_nibble: serial UART receiver for 8N1-style frames carrying DW data bits (LSB first).
// Each correctly framed word is presented on data together with a one-cycle come strobe; a low
// stop bit raises a one-cycle ferr strobe instead and the receiver then waits for the line to go
// high again before looking for the next start bit.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-low reset
//   rxd   in   serial line, idle high, asynchronous to clk
//   data  out  last correctly framed word (reset all-ones)
//   come  out  one-cycle strobe per good frame
//   ferr  out  one-cycle strobe per bad stop bit
//   busy  out  high whenever the receiver is not idle
module uart_rx_nibble #(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned DW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rxd,
  output logic [DW-1:0] data,
  output logic          come,
  output logic          ferr,
  output logic          busy
);

  localparam int unsigned HALF = BAUD_DIV / 2;
  localparam int unsigned IW   = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [15:0]   HalfLoad = 16'(HALF - 1);
  localparam logic [15:0]   BaudLoad = 16'(BAUD_DIV - 1);
  localparam logic [IW-1:0] IdxLast  = IW'(DW - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e        state;
  logic          s1;
  logic          s2;
  logic [15:0]   cnt;
  logic [IW-1:0] idx;
  logic [DW-1:0] sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= StIdle;
      s1    <= 1'b1;
      s2    <= 1'b1;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      data  <= '1;
      come  <= 1'b0;
      ferr  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      s1   <= rxd;
      s2   <= s1;
      // Strobes last exactly one cycle unless re-raised below.
      come <= 1'b0;
      ferr <= 1'b0;

      case (state)
        StIdle: begin
          if (!s2) begin
            state <= StStart;
            cnt   <= HalfLoad;
            busy  <= 1'b1;
          end
        end

        // Wait to the middle of the start bit and confirm it is still low.
        StStart: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if (s2) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else begin
            state <= StData;
            cnt   <= BaudLoad;
            idx   <= '0;
          end
        end

        StData: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else begin
            sh[idx] <= s2;
            cnt     <= BaudLoad;
            if (idx == IdxLast) begin
              state <= StStop;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        // Returning to idle at the stop-bit midpoint lets a back-to-back start bit be caught.
        StStop: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if (s2) begin
            data  <= sh;
            come  <= 1'b1;
            state <= StIdle;
            busy  <= 1'b0;
          end else begin
            ferr  <= 1'b1;
            state <= StBreak;
          end
        end

        // Hold off until the line is released so a break never looks like new frames.
        StBreak: begin
          if (s2) begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
